// File: rtl/reg_file_param.sv
// Parametrised general-purpose register file with zero-reading entry 0,
// optional write-to-read bypass, synchronous bulk clear and an IRST command
// register (loaded by writes to address 0) with a valid/done handshake.
//
// IRST state | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no command outstanding; irst_done pulses are ignored
// PENDING    | irst_cmd holds a command not yet consumed by the IRST unit
module reg_file_param #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter int                NUM_RD    = 2,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] IRST_INIT = DATA_W'(16'h8F04)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0]        irst_cmd,
  output logic                     irst_valid,
  input  logic                     irst_done,
  output logic                     irst_overrun
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } irst_state_t;

  localparam irst_state_t RST_STATE = (IRST_INIT != '0) ? PENDING : IDLE;

  // Entry 0 is only ever written by reset; reads of address 0 bypass it.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  irst_state_t       state_q, state_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic              ovr_q, ovr_d;
  logic              cmd_wr;

  assign cmd_wr = wr_en && (wr_addr == '0);

  // GPR storage: async reset, clear beats a simultaneous write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = BYPASS && wr_en && !clr && (wr_addr == ra);
    assign rd_data[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : (hit ? wr_data : mem[ra]);
  end

  // IRST state register, command and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cmd_q   <= IRST_INIT;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ovr_q   <= ovr_d;
    end
  end

  // IRST next-state: a new command always wins over a same-cycle done.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (cmd_wr) begin
          state_d = PENDING;
          cmd_d   = wr_data;
        end
      end
      PENDING: begin
        if (cmd_wr) begin
          cmd_d = wr_data;
          if (!irst_done) ovr_d = 1'b1;
        end else if (irst_done) begin
          state_d = IDLE;
          cmd_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // IRST outputs straight from registers.
  always_comb begin
    irst_valid   = (state_q == PENDING);
    irst_cmd     = cmd_q;
    irst_overrun = ovr_q;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (default 16x8/2-port/bypass and a
// 32x16/4-port/no-bypass variant) share stimulus; a reference model pushes
// expected outputs to a scoreboard that a negedge monitor drains.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, irst_done;
  logic [2:0]  wr_addr_a;
  logic [3:0]  wr_addr_b;
  logic [15:0] wr_data_a;
  logic [31:0] wr_data_b;
  logic [5:0]  rd_addr_a;
  logic [15:0] rd_addr_b;
  logic [31:0] rd_data_a;
  logic [127:0] rd_data_b;
  logic [15:0] cmd_a;
  logic [31:0] cmd_b;
  logic        valid_a, valid_b, ovr_a, ovr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_param dut_a (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .irst_cmd(cmd_a), .irst_valid(valid_a), .irst_done(irst_done), .irst_overrun(ovr_a)
  );

  reg_file_param #(
    .DATA_W(32), .ADDR_W(4), .NUM_RD(4), .BYPASS(1'b0), .IRST_INIT(32'h0)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .irst_cmd(cmd_b), .irst_valid(valid_b), .irst_done(irst_done), .irst_overrun(ovr_b)
  );

  typedef struct packed {
    logic [1:0][3:0][31:0] rd;
    logic [1:0][31:0]      cmd;
    logic [1:0]            v;
    logic [1:0]            o;
  } exp_t;

  exp_t sb[$];

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  logic [31:0] m_gpr [2][16];
  logic [31:0] m_cmd [2];
  bit          m_pend [2];
  bit          m_ovr [2];

  function automatic logic [3:0] amask(int i);
    return (i == 0) ? 4'h7 : 4'hF;
  endfunction
  function automatic logic [31:0] dmask(int i);
    return (i == 0) ? 32'h0000FFFF : 32'hFFFFFFFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) m_gpr[i][j] = '0;
      m_cmd[i]  = (i == 0) ? 32'h8F04 : 32'h0;
      m_pend[i] = (m_cmd[i] != 0);
      m_ovr[i]  = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, idx, $time, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [15:0] ra, input bit done);
    exp_t        e;
    logic [3:0]  wa_i, a;
    logic [31:0] wd_i;
    bit          byp;
    @(posedge clk);
    #1;
    rst = r; clr = c; wr_en = we; irst_done = done;
    wr_addr_b = wa; wr_addr_a = wa[2:0];
    wr_data_b = wd; wr_data_a = wd[15:0];
    rd_addr_b = ra; rd_addr_a = {ra[6:4], ra[2:0]};
    if (r) model_reset();
    e = '0;
    for (int i = 0; i < 2; i++) begin
      wa_i = wa & amask(i);
      wd_i = wd & dmask(i);
      byp  = (i == 0);
      for (int k = 0; k < 4; k++) begin
        a = ra[k*4 +: 4] & amask(i);
        if ((i == 0 && k >= 2) || a == 0) e.rd[i][k] = '0;
        else if (byp && we && !c && wa_i == a) e.rd[i][k] = wd_i;
        else e.rd[i][k] = m_gpr[i][a];
      end
      e.cmd[i] = m_cmd[i];
      e.v[i]   = m_pend[i];
      e.o[i]   = m_ovr[i];
    end
    sb.push_back(e);
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        wa_i = wa & amask(i);
        wd_i = wd & dmask(i);
        if (c) begin
          for (int j = 1; j < 16; j++) m_gpr[i][j] = '0;
        end else if (we && wa_i != 0) begin
          m_gpr[i][wa_i] = wd_i;
        end
        if (we && wa_i == 0) begin
          if (m_pend[i] && !done) m_ovr[i] = 1'b1;
          m_cmd[i]  = wd_i;
          m_pend[i] = 1'b1;
        end else if (m_pend[i] && done) begin
          m_cmd[i]  = '0;
          m_pend[i] = 1'b0;
        end
      end
    end
  endtask

  // Monitor: compare every cycle's presented outputs against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 2; k++) chk("rd_a", k, {16'h0, rd_data_a[k*16 +: 16]}, e.rd[0][k]);
        for (int k = 0; k < 4; k++) chk("rd_b", k, rd_data_b[k*32 +: 32], e.rd[1][k]);
        chk("cmd_a", 0, {16'h0, cmd_a}, e.cmd[0]);
        chk("cmd_b", 1, cmd_b, e.cmd[1]);
        chk("valid", 0, {31'h0, valid_a}, {31'h0, e.v[0]});
        chk("valid", 1, {31'h0, valid_b}, {31'h0, e.v[1]});
        chk("overrun", 0, {31'h0, ovr_a}, {31'h0, e.o[0]});
        chk("overrun", 1, {31'h0, ovr_b}, {31'h0, e.o[1]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          r, c, we, done;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [15:0] ra;
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; irst_done = 1'b0;
    wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    model_reset();

    // reset values, then consume the reset-time IRST command
    step(1, 0, 0, 4'h0, 32'h0, 16'h0000, 0);
    step(1, 0, 0, 4'h0, 32'h0, 16'h4321, 0);
    step(0, 0, 0, 4'h0, 32'h0, 16'h0000, 0);
    step(0, 0, 0, 4'h0, 32'h0, 16'h0000, 1);
    step(0, 0, 0, 4'h0, 32'h0, 16'h0000, 1);
    // bypass vs stored read of r3
    step(0, 0, 1, 4'h3, 32'h0000BEEF, 16'h0003, 0);
    step(0, 0, 0, 4'h0, 32'h0, 16'h0003, 0);
    // IRST command, then overrun
    step(0, 0, 1, 4'h0, 32'h00001234, 16'h0030, 0);
    step(0, 0, 1, 4'h0, 32'h00005678, 16'h0030, 0);
    step(0, 0, 0, 4'h0, 32'h0, 16'h0000, 0);
    // new command with simultaneous done: no overrun
    step(1, 0, 0, 4'h0, 32'h0, 16'h0000, 0);
    step(0, 0, 0, 4'h0, 32'h0, 16'h0000, 1);
    step(0, 0, 1, 4'h0, 32'h00001111, 16'h0000, 0);
    step(0, 0, 1, 4'h0, 32'h0000AAAA, 16'h0000, 1);
    step(0, 0, 0, 4'h0, 32'h0, 16'h0000, 0);
    // fill r1..r7 then clear with a colliding write
    for (int j = 1; j < 8; j++) step(0, 0, 1, 4'(j), 32'(j), 16'h0021, 0);
    step(0, 1, 1, 4'h5, 32'h9, 16'h0075, 0);
    for (int j = 1; j < 8; j++) step(0, 0, 0, 4'h0, 32'h0, {8'h0, 4'(j), 4'(8 - j)}, 0);
    // wide instance: r15 on all four ports, then reset mid-pending
    step(0, 0, 1, 4'hF, 32'hDEADBEEF, 16'hFFFF, 0);
    step(0, 0, 0, 4'h0, 32'h0, 16'hFFFF, 0);
    step(0, 0, 1, 4'h0, 32'hCAFEF00D, 16'hFFFF, 0);
    step(0, 0, 0, 4'h0, 32'h0, 16'hFFFF, 0);
    step(1, 0, 0, 4'h0, 32'h0, 16'hFFFF, 1);
    step(0, 0, 0, 4'h0, 32'h0, 16'hFFFF, 0);

    for (int n = 0; n < 400; n++) begin
      r    = ($urandom_range(0, 63) == 0);
      c    = ($urandom_range(0, 15) == 0);
      we   = ($urandom_range(0, 3) != 0);
      wa   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      wd   = $urandom;
      ra   = 16'($urandom);
      done = ($urandom_range(0, 3) == 0);
      step(r, c, we, wa, wd, ra, done);
    end

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the mips_16 general-purpose register file.
- Configurable data width, depth and read-port count; optional write-to-read bypass; synchronous bulk clear.
- Entry 0 still reads as zero on every architectural read port. Writes to address 0 are not discarded: they load a dedicated IRST command register, which has a valid/done handshake towards the IRST unit.
- Sits between the decode stage (read ports), the write-back stage (write port) and the IRST controller.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W entries (entry 0 reserved).
- NUM_RD, 2, number of asynchronous read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns stored value.
- IRST_INIT, 16'h8F04, IRST command loaded at reset (DATA_W bits). Value 0 = IRST inactive after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of entries 1..2**ADDR_W-1.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W].
- irst_cmd  out  DATA_W  current IRST command register.
- irst_valid  out  1  command pending.
- irst_done  in  1  single-cycle pulse from the IRST unit: command consumed.
- irst_overrun  out  1  sticky; a new command was written while one was already pending.

Behaviour:
- Reset (async, rst=1):
  - All GPR entries = 0.
  - irst_cmd = IRST_INIT; irst_valid = (IRST_INIT != 0); irst_overrun = 0.
  - rd_data follows the reset contents combinationally.
- Reads (combinational, zero latency), per port k:
  - rd_addr_k == 0 -> 0.
  - else if BYPASS=1 and wr_en and wr_addr == rd_addr_k and clr=0 -> wr_data.
  - else -> stored entry.
- GPR write: on posedge clk, wr_en=1 and wr_addr != 0 -> entry[wr_addr] <= wr_data.
- clr=1: all entries 1.. <= 0 on posedge, and a simultaneous GPR write is dropped (clr wins). With clr=1, bypass is suppressed and reads return the stored value. The IRST register is unaffected by clr.
- IRST FSM, state carried by irst_valid:
  - IDLE (valid=0): wr_en & wr_addr==0 -> irst_cmd <= wr_data, go to PENDING. Writing data 0 still goes to PENDING.
  - PENDING (valid=1): irst_done=1 -> irst_cmd <= 0, go to IDLE.
  - PENDING: wr_en & wr_addr==0 without done -> irst_cmd <= wr_data, stay PENDING, irst_overrun <= 1.
  - PENDING: write to 0 and irst_done in the same cycle -> new command wins: irst_cmd <= wr_data, stay PENDING, no overrun.
  - IDLE: irst_done is ignored (no state change).
  - irst_overrun clears only on rst.
- irst_cmd and irst_valid are registered outputs; a write to address 0 is visible on the next cycle.
- Reset asserted mid-handshake returns to the reset values; a pending done pulse is lost.
- Widths: no arithmetic; all data paths are DATA_W wide; no truncation or extension.

Test Plan:
- Reset, IRST_INIT=16'h8F04 -> irst_cmd=8F04, irst_valid=1, rd_data all 0; pulse irst_done -> next cycle irst_cmd=0, irst_valid=0.
- Write r3=16'hBEEF; set port0 addr=3, port1 addr=0 -> port0=BEEF from the same cycle (BYPASS=1), port1=0; with BYPASS=0 -> port0=BEEF only after the clock edge.
- Write r0=16'h1234 while IDLE -> next cycle irst_cmd=1234, valid=1; write r0=16'h5678 without done -> cmd=5678, overrun=1.
- While PENDING, write r0=16'hAAAA and irst_done in the same cycle -> cmd=AAAA, valid=1, overrun unchanged (0).
- Fill r1..r7 with 1..7, then clr=1 together with a write r5=9 -> all of r1..r7 read 0 the next cycle, irst_cmd unchanged.
- NUM_RD=4, ADDR_W=4, DATA_W=32: write r15=32'hDEADBEEF; all four ports at addr 15 -> all return DEADBEEF; assert rst mid-PENDING -> state returns to reset values.
